tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the team's 4:1 multiplexed serial link. It takes one serial bit stream framed by a sync pulse and deserializes it into four WIDTH-bit channel words. Each completed word is presented on a registered per-channel output with a one-cycle valid strobe. It sits between the serial link input and the per-channel consumers.

## Interface
- WIDTH, 8, bits per channel word; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit; MSB first, channel 0 first.
- din_en  input  1  din is valid this cycle. Bits are sampled only when din_en=1.
- frame_sync  input  1  marks the first bit (ch0 MSB) of a frame. Meaningful only when din_en=1.
- data_out  output  4*WIDTH  channel registers; ch N occupies bits [N*WIDTH +: WIDTH].
- ch_valid  output  4  one-cycle strobe; bit N is set in the cycle data_out channel N has just been updated.
- frame_valid  output  1  one-cycle strobe when channel 3 completes a frame.
- sync_err  output  1  one-cycle strobe when frame_sync arrives mid-frame.
- busy  output  1  high while a frame is in progress (state RECV).

## Operation
- State machine with two states:
  - IDLE: hunting for sync.
  - RECV: assembling a frame.
- Internal registers:
  - shift register sreg[WIDTH-1:0], which shifts left and takes din into the LSB.
  - bit_cnt, 0..WIDTH-1.
  - ch_sel, 2 bits.
- IDLE behaviour:
  - din_en=1 and frame_sync=1: shift din in, set bit_cnt=1 and ch_sel=0, go to RECV.
  - Any other input: ignored; all state holds.
- RECV behaviour, on each cycle with din_en=1 and frame_sync=0:
  - Shift din in.
  - If bit_cnt==WIDTH-1: write {sreg[WIDTH-2:0],din} to channel ch_sel, set ch_valid[ch_sel], clear bit_cnt, increment ch_sel.
  - Otherwise bit_cnt increments.
  - If the completed channel was ch_sel==3: also set frame_valid, set ch_sel to 0, go to IDLE.
- RECV with din_en=0: all state holds, and no strobes are generated. Gaps of any length are legal.
- RECV with din_en=1 and frame_sync=1 (resync):
  - Pulse sync_err.
  - Discard the partial word.
  - Restart the frame with this bit as ch0 MSB: bit_cnt=1, ch_sel=0, stay in RECV.
  - Channels already written in the aborted frame keep their new values.
  - frame_valid is not generated for the aborted frame.
- frame_sync with din_en=0 is ignored in every state.
- Back-to-back frames: the bit immediately after the ch3 LSB may carry frame_sync. It is accepted from IDLE in that cycle with no lost bit.
- Only data_out bits of the channel being written change; the other channels hold.

## Timing
- Reset values, asynchronous: data_out=0, ch_valid=0, frame_valid=0, sync_err=0, busy=0, state=IDLE, sreg=0, bit_cnt=0, ch_sel=0.
- Reset asserted mid-frame: everything returns to reset values immediately. The frame in progress is lost. After release, reception resumes only at the next frame_sync.
- Latency: data_out[ch N] and ch_valid[N] update on the same rising edge that samples the channel's LSB. They are visible for the following cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- ch_valid, frame_valid and sync_err are high for exactly one cycle per event.
- frame_valid is coincident with ch_valid[3].
- busy rises on the edge that accepts sync and falls on the edge that completes ch3.
- Minimum frame time is 4*WIDTH cycles with din_en held high.

## Test plan
- Reset check:
  - Stimulus: rst_n low for 3 cycles, then release.
  - Required: all outputs 0; busy=0.
- Continuous frame, WIDTH=8:
  - Stimulus: din_en=1 constantly; send 0x9A, 0x35, 0xC6, 0x0F, with frame_sync on the first bit.
  - Required: ch_valid pulses 0001, 0010, 0100, 1000 at cycles 8, 16, 24, 32 after sync. frame_valid coincident with the last. data_out=0x0FC6359A.
- Gapped input:
  - Stimulus: same frame as above, with din_en low for 3 cycles after every 2nd bit.
  - Required: identical data_out; strobes delayed accordingly; no strobes during gaps.
- Noise and back-to-back:
  - Stimulus: in IDLE, bits with din_en=1 but no sync; frame_sync with din_en=0. Then two back-to-back frames 0x11223344 and 0xA5A55A5A.
  - Required: no action from the noise. data_out=0x44332211, then 0x5A5AA5A5. Two frame_valid pulses exactly 32 cycles apart.
- Resync:
  - Stimulus: frame_sync asserted at bit 3 of ch1; then a full frame 0x01020304.
  - Required: sync_err pulses once. ch0 holds the aborted frame's ch0 value until overwritten. No frame_valid for the aborted frame. The final data_out is 0x04030201.
- Reset mid-frame:
  - Stimulus: rst_n low during ch2.
  - Required: data_out=0 immediately; busy=0. A subsequent full frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux4.sv
// Receive end of the 4:1 TDM serial link: deserializes a sync-framed bit stream into four WIDTH-bit channel registers.
// Channel word lands on the edge sampling its LSB; din_en low stalls everything (no backpressure to the link).
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 din_en,
    input  logic                 frame_sync,
    output logic [4*WIDTH-1:0]   data_out,
    output logic [3:0]           ch_valid,
    output logic                 frame_valid,
    output logic                 sync_err,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t               state_q, state_d;
    // Only WIDTH-1 history bits are kept; a word's LSB comes straight from din.
    logic [WIDTH-2:0]     sreg_q, sreg_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           ch_sel_q, ch_sel_d;
    logic [4*WIDTH-1:0]   data_q, data_d;
    logic [3:0]           ch_valid_q, ch_valid_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 sync_err_q, sync_err_d;
    logic [WIDTH-1:0]     shifted;

    assign shifted = {sreg_q, din};

    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        bit_cnt_d     = bit_cnt_q;
        ch_sel_d      = ch_sel_q;
        data_d        = data_q;
        ch_valid_d    = '0;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_en) begin
            if (frame_sync) begin
                // Sync always restarts the frame at ch0; mid-frame it also flags an error.
                sync_err_d = (state_q == RECV);
                sreg_d     = shifted[WIDTH-2:0];
                bit_cnt_d  = CW'(1);
                ch_sel_d   = 2'd0;
                state_d    = RECV;
            end else if (state_q == RECV) begin
                sreg_d = shifted[WIDTH-2:0];
                if (bit_cnt_q == LAST_BIT) begin
                    data_d[int'(ch_sel_q)*WIDTH +: WIDTH] = shifted;
                    ch_valid_d[ch_sel_q] = 1'b1;
                    bit_cnt_d = '0;
                    ch_sel_d  = ch_sel_q + 2'd1;
                    if (ch_sel_q == 2'd3) begin
                        frame_valid_d = 1'b1;
                        state_d       = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sreg_q        <= '0;
            bit_cnt_q     <= '0;
            ch_sel_q      <= '0;
            data_q        <= '0;
            ch_valid_q    <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            bit_cnt_q     <= bit_cnt_d;
            ch_sel_q      <= ch_sel_d;
            data_q        <= data_d;
            ch_valid_q    <= ch_valid_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign data_out    = data_q;
    assign ch_valid    = ch_valid_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign busy        = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized bench for tdm_demux4 against a frame-position reference model, plus directed literal checks.
module tb_tdm_demux4;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           din = 1'b0;
    logic           din_en = 1'b0;
    logic           frame_sync = 1'b0;
    logic [4*W-1:0] data_out;
    logic [3:0]     ch_valid;
    logic           frame_valid;
    logic           sync_err;
    logic           busy;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_en      (din_en),
        .frame_sync  (frame_sync),
        .data_out    (data_out),
        .ch_valid    (ch_valid),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sync_cyc = 0;
    int se_cnt = 0;
    int chv_cyc[$];
    int fv_cyc[$];

    // Reference model: pos = bits received in the current frame (0 = hunting).
    logic [W-1:0] m_data[4];
    logic [3:0]   m_chv;
    logic         m_fv, m_se;
    int           pos;
    logic [31:0]  acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_data[i] = '0;
        m_chv = '0;
        m_fv  = 1'b0;
        m_se  = 1'b0;
        pos   = 0;
        acc   = '0;
    endtask

    task automatic model_update(input logic en, input logic fs, input logic d);
        int ch;
        m_chv = '0;
        m_fv  = 1'b0;
        m_se  = 1'b0;
        if (en) begin
            if (fs) begin
                m_se = (pos != 0);
                pos  = 1;
                acc  = {31'd0, d};
            end else if (pos != 0) begin
                acc = {acc[30:0], d};
                pos = pos + 1;
                if (pos % W == 0) begin
                    ch = pos / W - 1;
                    m_data[ch] = acc[W-1:0];
                    m_chv[ch]  = 1'b1;
                    if (ch == 3) begin
                        m_fv = 1'b1;
                        pos  = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("data_out", 64'(data_out), 64'({m_data[3], m_data[2], m_data[1], m_data[0]}));
        chk("ch_valid", 64'(ch_valid), 64'(m_chv));
        chk("frame_valid", 64'(frame_valid), 64'(m_fv));
        chk("sync_err", 64'(sync_err), 64'(m_se));
        chk("busy", 64'(busy), 64'(pos != 0));
        if (ch_valid != 4'd0) chv_cyc.push_back(cyc);
        if (frame_valid) fv_cyc.push_back(cyc);
        if (sync_err) se_cnt++;
    endtask

    // Inputs change on the falling edge; the DUT samples on the next rising edge.
    task automatic step(input logic en, input logic fs, input logic d);
        din_en     = en;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        cyc++;
        if (rst_n) model_update(en, fs, d);
        if (rst_n && en && fs) sync_cyc = cyc;
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_frame(input logic [31:0] f, input int gap_every);
        for (int b = 0; b < 32; b++) begin
            step(1'b1, b == 0, f[31-b]);
            if (gap_every > 0 && (b % gap_every) == gap_every - 1)
                for (int g = 0; g < 3; g++) step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic rst_pulse();
        din_en = 1'b0;
        frame_sync = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_data", 64'(data_out), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        int f0;
        int se0;
        logic [10:0] abort_bits;

        // Reset
        #1 rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("reset_data", 64'(data_out), 64'd0);
        chk("reset_strobes", 64'({ch_valid, frame_valid, sync_err, busy}), 64'd0);

        // Continuous frame
        n0 = chv_cyc.size();
        f0 = fv_cyc.size();
        send_frame(32'h9A35C60F, 0);
        chk("cont_data", 64'(data_out), 64'h0FC6359A);
        chk("cont_nstrobes", 64'(chv_cyc.size() - n0), 64'd4);
        if (chv_cyc.size() - n0 == 4)
            for (int k = 0; k < 4; k++)
                chk("cont_chv_time", 64'(chv_cyc[n0+k] - sync_cyc), 64'(7 + 8 * k));
        chk("cont_nfv", 64'(fv_cyc.size() - f0), 64'd1);
        if (fv_cyc.size() - f0 == 1)
            chk("cont_fv_time", 64'(fv_cyc[f0] - sync_cyc), 64'd31);

        // Noise in IDLE, then back-to-back frames
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'($urandom));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom));
        chk("noise_data", 64'(data_out), 64'h0FC6359A);
        chk("noise_busy", 64'(busy), 64'd0);
        f0 = fv_cyc.size();
        send_frame(32'h11223344, 0);
        chk("b2b_data1", 64'(data_out), 64'h44332211);
        send_frame(32'hA5A55A5A, 0);
        chk("b2b_data2", 64'(data_out), 64'h5A5AA5A5);
        chk("b2b_nfv", 64'(fv_cyc.size() - f0), 64'd2);
        if (fv_cyc.size() - f0 == 2)
            chk("b2b_fv_gap", 64'(fv_cyc[f0+1] - fv_cyc[f0]), 64'd32);

        // Gapped frame: ch3 completes 45 gap cycles later than unbroken timing
        f0 = fv_cyc.size();
        send_frame(32'h9A35C60F, 2);
        chk("gap_data", 64'(data_out), 64'h0FC6359A);
        if (fv_cyc.size() - f0 == 1)
            chk("gap_fv_time", 64'(fv_cyc[f0] - sync_cyc), 64'd76);
        else
            chk("gap_nfv", 64'(fv_cyc.size() - f0), 64'd1);

        // Resync at bit 3 of ch1
        se0 = se_cnt;
        f0 = fv_cyc.size();
        abort_bits = 11'b01110111_101;
        for (int i = 0; i < 11; i++) step(1'b1, i == 0, abort_bits[10-i]);
        chk("resync_ch0_aborted", 64'(data_out[7:0]), 64'h77);
        step(1'b1, 1'b1, 1'b0);
        chk("resync_err_count", 64'(se_cnt - se0), 64'd1);
        chk("resync_ch0_hold", 64'(data_out[7:0]), 64'h77);
        for (int b = 1; b < 32; b++) step(1'b1, 1'b0, 1'(32'h01020304 >> (31 - b)));
        chk("resync_data", 64'(data_out), 64'h04030201);
        chk("resync_nfv", 64'(fv_cyc.size() - f0), 64'd1);
        chk("resync_err_total", 64'(se_cnt - se0), 64'd1);

        // Reset during ch2
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'($urandom));
        rst_pulse();
        step(1'b1, 1'b0, 1'b1);
        chk("post_rst_idle", 64'(busy), 64'd0);
        send_frame(32'hDEADBEEF, 0);
        chk("post_rst_data", 64'(data_out), 64'hEFBEADDE);

        // Randomized traffic
        for (int it = 0; it < 3000; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r == 0)
                rst_pulse();
            else if (r < 4)
                send_frame($urandom, $urandom_range(0, 3));
            else
                step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
